// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer/status controller of an asynchronous FIFO (rclk domain).
// Tracks binary/Gray read pointers against the synchronized Gray write pointer.
module rptr_empty_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int AEMPTY_TH = 2
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rinc,
  input  logic                 rerr_clr,
  input  logic [ADDR_SIZE:0]   rq2_wptr,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rempty,
  output logic                 ralmost_empty,
  output logic [ADDR_SIZE:0]   rlevel,
  output logic                 rerr_underflow
);

  localparam logic [ADDR_SIZE:0] AE_TH = (ADDR_SIZE+1)'(AEMPTY_TH);

  logic [ADDR_SIZE:0] rbin;
  logic [ADDR_SIZE:0] rbinnext;
  logic [ADDR_SIZE:0] rgraynext;
  logic [ADDR_SIZE:0] wbin_s;
  logic [ADDR_SIZE:0] diff;
  logic               ren;

  assign ren       = rinc & ~rempty;
  assign rbinnext  = rbin + (ADDR_SIZE+1)'(ren);
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign raddr     = rbin[ADDR_SIZE-1:0];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ADDR_SIZE; i++) begin
      wbin_s[i] = ^(rq2_wptr >> i);
    end
  end

  // Level and almost-empty share this difference so both flags stay aligned.
  assign diff = wbin_s - rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin           <= '0;
      rptr           <= '0;
      rempty         <= 1'b1;
      ralmost_empty  <= 1'b1;
      rlevel         <= '0;
      rerr_underflow <= 1'b0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= (rgraynext == rq2_wptr);
      ralmost_empty <= (diff <= AE_TH);
      rlevel        <= diff;
      if (rinc && rempty) begin
        rerr_underflow <= 1'b1;
      end else if (rerr_clr) begin
        rerr_underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Scoreboard bench for rptr_empty_ctrl (ADDR_SIZE=4, AEMPTY_TH=2): driver pushes
// expected post-edge outputs, a monitor pops and compares one entry per cycle.
module tb_rptr_empty_ctrl;

  localparam int AS = 4;
  localparam int EW = 17;

  logic          rclk;
  logic          rrst_n;
  logic          rinc;
  logic          rerr_clr;
  logic [AS:0]   rq2_wptr;
  logic [AS-1:0] raddr;
  logic [AS:0]   rptr;
  logic          rempty;
  logic          ralmost_empty;
  logic [AS:0]   rlevel;
  logic          rerr_underflow;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  // model state for the streaming phases
  int  m_rb;
  int  m_w;
  bit  m_empty;
  bit  m_err;

  rptr_empty_ctrl #(.ADDR_SIZE(AS), .AEMPTY_TH(2)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rerr_clr(rerr_clr),
    .rq2_wptr(rq2_wptr), .raddr(raddr), .rptr(rptr), .rempty(rempty),
    .ralmost_empty(ralmost_empty), .rlevel(rlevel), .rerr_underflow(rerr_underflow)
  );

  // clock / reset block
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [EW-1:0] pack(input logic [4:0] p, input logic [3:0] a,
                                         input logic e, input logic ae,
                                         input logic [4:0] l, input logic er);
    return {p, a, e, ae, l, er};
  endfunction

  function automatic logic [EW-1:0] dut_vec();
    return pack(rptr, raddr, rempty, ralmost_empty, rlevel, rerr_underflow);
  endfunction

  task automatic report(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got rptr=%b raddr=%0d empty=%b aempty=%b level=%0d err=%b, required rptr=%b raddr=%0d empty=%b aempty=%b level=%0d err=%b",
                  name, got[16:12], got[11:8], got[7], got[6], got[5:1], got[0],
                  exp[16:12], exp[11:8], exp[7], exp[6], exp[5:1], exp[0]);
  endtask

  // monitor: outputs are presented every cycle; compare one entry per edge
  initial begin
    forever begin
      @(posedge rclk);
      #1;
      if (exp_q.size() != 0) report("cycle", dut_vec(), exp_q.pop_front());
    end
  end

  // driver: apply inputs on the negedge, push expected outputs after next posedge
  task automatic step(input logic inc, input logic clr, input logic [4:0] wg,
                      input logic [EW-1:0] exp);
    @(negedge rclk);
    rinc     = inc;
    rerr_clr = clr;
    rq2_wptr = wg;
    exp_q.push_back(exp);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rinc = 1'b0; rerr_clr = 1'b0; rq2_wptr = '0;
    #2 rrst_n = 1'b0;
    #1 report("async_reset", dut_vec(), pack(5'b0, 4'd0, 1'b1, 1'b1, 5'd0, 1'b0));
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  // reference model for streamed traffic; w is the binary write count
  task automatic model_step(input bit inc, input bit clr, input int w);
    int ren, rbn, lvl;
    bit e, ae, er;
    ren = (inc && !m_empty) ? 1 : 0;
    rbn = (m_rb + ren) % 32;
    lvl = ((w - rbn) % 32 + 32) % 32;
    e   = (rbn == w);
    ae  = (lvl <= 2);
    er  = (inc && m_empty) ? 1'b1 : (clr ? 1'b0 : m_err);
    step(inc, clr, 5'(w ^ (w >> 1)),
         pack(5'(rbn ^ (rbn >> 1)), 4'(rbn % 16), e, ae, 5'(lvl), er));
    m_rb = rbn; m_w = w; m_empty = e; m_err = er;
  endtask

  initial begin
    int guard;
    rrst_n = 1'b1; rinc = 1'b0; rerr_clr = 1'b0; rq2_wptr = '0;
    repeat (2) @(posedge rclk);
    do_reset();
    step(0, 0, 5'b00000, pack(5'b00000, 4'd0, 1, 1, 5'd0, 0));
    step(0, 0, 5'b00000, pack(5'b00000, 4'd0, 1, 1, 5'd0, 0));

    // fill to 3 then drain
    step(0, 0, 5'b00010, pack(5'b00000, 4'd0, 0, 0, 5'd3, 0));
    step(1, 0, 5'b00010, pack(5'b00001, 4'd1, 0, 1, 5'd2, 0));
    step(1, 0, 5'b00010, pack(5'b00011, 4'd2, 0, 1, 5'd1, 0));
    step(1, 0, 5'b00010, pack(5'b00010, 4'd3, 1, 1, 5'd0, 0));

    // underflow: sticky, set beats clear, clear alone drops it
    step(1, 0, 5'b00010, pack(5'b00010, 4'd3, 1, 1, 5'd0, 1));
    step(1, 0, 5'b00010, pack(5'b00010, 4'd3, 1, 1, 5'd0, 1));
    step(1, 1, 5'b00010, pack(5'b00010, 4'd3, 1, 1, 5'd0, 1));
    step(0, 1, 5'b00010, pack(5'b00010, 4'd3, 1, 1, 5'd0, 0));
    step(0, 0, 5'b00010, pack(5'b00010, 4'd3, 1, 1, 5'd0, 0));

    // full view after a mid-operation reset
    do_reset();
    step(0, 0, 5'b11000, pack(5'b00000, 4'd0, 0, 0, 5'd16, 0));
    step(0, 0, 5'b11000, pack(5'b00000, 4'd0, 0, 0, 5'd16, 0));

    // wrap-around stream: pop every cycle, write on two of every three cycles
    m_rb = 0; m_w = 16; m_empty = 0; m_err = 0;
    for (int i = 0; i < 40; i++) begin
      model_step(1, 0, (i % 3 != 0) ? (m_w + 1) % 32 : m_w);
    end

    // drain to level 1, then pop on the same edge the write pointer advances
    guard = 0;
    while ((((m_w - m_rb) % 32 + 32) % 32) > 1 && guard < 40) begin
      model_step(1, 0, m_w);
      guard++;
    end
    model_step(1, 0, (m_w + 1) % 32);
    step(0, 0, 5'(m_w ^ (m_w >> 1)),
         pack(5'(m_rb ^ (m_rb >> 1)), 4'(m_rb % 16), 0, 1, 5'd1, 0));
    m_empty = 0;

    // drain to empty and underflow once more through the model
    model_step(1, 0, m_w);
    model_step(1, 0, m_w);
    model_step(0, 1, m_w);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge rclk);
      guard++;
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
